// File: rtl/muldiv_unit.sv
// muldiv_unit - RV32M/RV64M multiply/divide execution unit beside the EX-stage ALU.
// MUL* run in one cycle (FAST_MUL=1) or as a shift-add over XLEN cycles (FAST_MUL=0).
// DIV*/REM* run as an XLEN-step restoring divide on operand magnitudes, followed by a sign fix.
// Divide by zero and signed overflow are resolved at accept and go straight to DONE.
//
// Ports:
//   clk, reset         clock (rising edge), asynchronous active-high reset
//   start_valid/ready  request handshake; ready only in IDLE
//   funct3, rs1, rs2   operation code and operands, captured at accept
//   kill               synchronous abort back to IDLE
//   res_valid/ready    result handshake; valid only in DONE
//   result             registered result, written on DONE entry only
//   busy               unit is not IDLE
//
// state | meaning
// IDLE  | waiting for a request
// MUL   | iterative shift-add multiply, one multiplier bit per cycle
// DIV   | restoring divide, one quotient bit per cycle
// DONE  | result held until the consumer takes it
module muldiv_unit #(
    parameter int XLEN     = 32,
    parameter bit FAST_MUL = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_valid,
    output logic            start_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            kill,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2:0]          op_q, op_d;
    logic                neg_q, neg_d;
    logic [2*XLEN-1:0]   a_q, a_d;      // multiplicand (shifts left) or divisor in low half
    logic [XLEN-1:0]     b_q, b_d;      // multiplier (shifts right)
    logic [2*XLEN-1:0]   acc_q, acc_d;  // product, or {remainder, dividend/quotient}
    logic [XLEN-1:0]     result_q, result_d;

    logic                a_signed, b_signed, sa, sb;
    logic [XLEN-1:0]     ma, mb;
    logic [2*XLEN-1:0]   fast_prod, mul_acc_nx, div_acc_nx;
    logic [XLEN:0]       rem_sh, rem_trial;
    logic                div_zero, div_ovf;

    // Apply the sign to the magnitude product, then choose the half the op asks for.
    function automatic logic [XLEN-1:0] mul_pick(input logic [2*XLEN-1:0] p,
                                                 input logic neg, input logic [2:0] op);
        logic [2*XLEN-1:0] s;
        s = neg ? -p : p;
        return (op[1:0] == 2'b00) ? s[XLEN-1:0] : s[2*XLEN-1:XLEN];
    endfunction

    function automatic logic [XLEN-1:0] div_pick(input logic [2*XLEN-1:0] acc,
                                                 input logic neg, input logic [2:0] op);
        logic [XLEN-1:0] v;
        v = op[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
        return neg ? -v : v;
    endfunction

    always_comb begin
        // MULH, MULHSU, DIV, REM treat rs1 as signed; MULH, DIV, REM treat rs2 as signed.
        a_signed  = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
        b_signed  = (funct3 == 3'b001) || (funct3[2] && !funct3[0]);
        sa        = a_signed && rs1[XLEN-1];
        sb        = b_signed && rs2[XLEN-1];
        ma        = sa ? -rs1 : rs1;
        mb        = sb ? -rs2 : rs2;
        fast_prod = {{XLEN{1'b0}}, ma} * {{XLEN{1'b0}}, mb};
        div_zero  = (rs2 == '0);
        div_ovf   = !funct3[0] && funct3[2] && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);

        mul_acc_nx = acc_q + (b_q[0] ? a_q : '0);

        // Remainder is always below the divisor, so the shifted value fits XLEN+1 bits
        // and bit XLEN of the trial difference is a reliable borrow.
        rem_sh    = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        rem_trial = rem_sh - {1'b0, a_q[XLEN-1:0]};
        if (!rem_trial[XLEN])
            div_acc_nx = {rem_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        else
            div_acc_nx = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};

        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (start_valid && !kill) begin
                    op_d  = funct3;
                    cnt_d = '0;
                    // REM takes the dividend's sign; everything else the sign product.
                    neg_d = (funct3 == 3'b110) ? sa : (sa ^ sb);
                    if (!funct3[2]) begin
                        a_d   = {{XLEN{1'b0}}, ma};
                        b_d   = mb;
                        acc_d = '0;
                        if (FAST_MUL) begin
                            result_d = mul_pick(fast_prod, (funct3 == 3'b110) ? sa : (sa ^ sb), funct3);
                            state_d  = S_DONE;
                        end else begin
                            state_d = S_MUL;
                        end
                    end else if (div_zero) begin
                        result_d = funct3[1] ? rs1 : '1;
                        state_d  = S_DONE;
                    end else if (div_ovf) begin
                        result_d = funct3[1] ? '0 : rs1;
                        state_d  = S_DONE;
                    end else begin
                        a_d     = {{XLEN{1'b0}}, mb};
                        acc_d   = {{XLEN{1'b0}}, ma};
                        state_d = S_DIV;
                    end
                end
            end
            S_MUL: begin
                acc_d = mul_acc_nx;
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(XLEN-1)) begin
                    result_d = mul_pick(mul_acc_nx, neg_q, op_q);
                    state_d  = S_DONE;
                end
            end
            S_DIV: begin
                acc_d = div_acc_nx;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(XLEN-1)) begin
                    result_d = div_pick(div_acc_nx, neg_q, op_q);
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (res_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Flush wins over everything, including a result that would land this edge.
        if (kill) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign start_ready = (state_q == S_IDLE) && !reset;
    assign res_valid   = (state_q == S_DONE);
    assign busy        = (state_q != S_IDLE);
    assign result      = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_valid = 1'b0;
    logic        kill = 1'b0;
    logic        res_ready = 1'b1;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;

    logic        start_ready_f, res_valid_f, busy_f;
    logic [31:0] result_f;
    logic        start_ready_s, res_valid_s, busy_s;
    logic [31:0] result_s;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32), .FAST_MUL(1'b1)) dut_f (
        .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(start_ready_f),
        .funct3(funct3), .rs1(rs1), .rs2(rs2), .kill(kill), .res_valid(res_valid_f),
        .res_ready(res_ready), .result(result_f), .busy(busy_f));

    muldiv_unit #(.XLEN(32), .FAST_MUL(1'b0)) dut_s (
        .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(start_ready_s),
        .funct3(funct3), .rs1(rs1), .rs2(rs2), .kill(kill), .res_valid(res_valid_s),
        .res_ready(res_ready), .result(result_s), .busy(busy_s));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 80; i++) begin
            if (!busy_f && !busy_s) break;
            @(negedge clk);
        end
        check("idle_before_op", {31'b0, busy_f | busy_s}, 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat_f, input int lat_s);
        logic df, ds;
        logic [31:0] rf, rs;
        int lf, ls;
        df = 1'b0; ds = 1'b0; rf = 'x; rs = 'x; lf = 0; ls = 0;
        wait_idle();
        @(negedge clk);
        funct3 = f3; rs1 = a; rs2 = b; start_valid = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        rs1 = $urandom; rs2 = $urandom; funct3 = 3'($urandom_range(0, 7));
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (!df && res_valid_f) begin df = 1'b1; lf = n; rf = result_f; end
            if (!ds && res_valid_s) begin ds = 1'b1; ls = n; rs = result_s; end
            if (df && ds) break;
        end
        check({tag, "_res_fast"}, rf, exp);
        check({tag, "_lat_fast"}, 32'(lf), 32'(lat_f));
        check({tag, "_res_iter"}, rs, exp);
        check({tag, "_lat_iter"}, 32'(ls), 32'(lat_s));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_start_ready", {31'b0, start_ready_s}, 32'd0);
        check("rst_busy", {31'b0, busy_s}, 32'd0);
        check("rst_res_valid", {31'b0, res_valid_s}, 32'd0);
        check("rst_result", result_s, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_start_ready", {31'b0, start_ready_f & start_ready_s}, 32'd1);

        // Multiplies
        run_op("mul",    3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 1, 33);
        run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, 33);
        run_op("mulh",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1, 33);
        run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 33);
        run_op("mulh_neg", 3'b001, 32'hFFFF_FFFD, 32'd5,      32'hFFFF_FFFF, 1, 33);

        // Divides
        run_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 33);
        run_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 33);
        run_op("div_nd", 3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 33);
        run_op("rem_nd", 3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1,         33, 33);
        run_op("divu",   3'b101, 32'd100, 32'd7, 32'd14, 33, 33);
        run_op("remu",   3'b111, 32'd100, 32'd7, 32'd2,  33, 33);

        // Special cases
        run_op("divu_z", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1);
        run_op("rem_z",  3'b110, 32'd5, 32'd0, 32'd5,         1, 1);
        run_op("div_ov", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1);
        run_op("rem_ov", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, 1);

        // Backpressure
        wait_idle();
        @(negedge clk);
        res_ready = 1'b0;
        funct3 = 3'b101; rs1 = 32'd100; rs2 = 32'd7; start_valid = 1'b1;
        @(posedge clk);
        #1 start_valid = 1'b0;
        repeat (33) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            check("bp_res_valid", {31'b0, res_valid_s}, 32'd1);
            check("bp_result", result_s, 32'd14);
            check("bp_start_ready", {31'b0, start_ready_s}, 32'd0);
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_ready", {31'b0, start_ready_s}, 32'd1);
        check("bp_release_valid", {31'b0, res_valid_s}, 32'd0);

        // Kill at divide iteration 5
        wait_idle();
        @(negedge clk);
        funct3 = 3'b100; rs1 = 32'd1000; rs2 = 32'd3; start_valid = 1'b1;
        @(posedge clk);
        #1 start_valid = 1'b0;
        repeat (6) @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1 kill = 1'b0;
        check("kill_busy", {31'b0, busy_s}, 32'd0);
        check("kill_start_ready", {31'b0, start_ready_s}, 32'd1);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (res_valid_s || res_valid_f) seen = 1'b1;
        end
        check("kill_no_valid", {31'b0, seen}, 32'd0);
        check("kill_stale_result", result_s, 32'd14);

        // Kill together with a request in IDLE
        @(negedge clk);
        funct3 = 3'b101; rs1 = 32'd9; rs2 = 32'd3; start_valid = 1'b1; kill = 1'b1;
        @(posedge clk);
        #1;
        start_valid = 1'b0; kill = 1'b0;
        check("kill_idle_no_accept", {31'b0, busy_s | busy_f}, 32'd0);

        // Asynchronous reset in the middle of an iterative multiply
        wait_idle();
        @(negedge clk);
        funct3 = 3'b000; rs1 = 32'd7; rs2 = 32'hFFFF_FFFD; start_valid = 1'b1;
        @(posedge clk);
        #1 start_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_mul_busy", {31'b0, busy_s}, 32'd1);
        reset = 1'b1;
        #1;
        check("arst_busy", {31'b0, busy_s}, 32'd0);
        check("arst_res_valid", {31'b0, res_valid_s}, 32'd0);
        check("arst_result_iter", result_s, 32'd0);
        check("arst_result_fast", result_f, 32'd0);
        check("arst_start_ready", {31'b0, start_ready_s}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("arst_release_ready", {31'b0, start_ready_s}, 32'd1);
        run_op("mul_after_rst", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1, 33);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
